// File: rtl/snake_pkg.sv
// Shared definitions for the snake direction scheduler.
//   dir_e   : direction encoding (00 up, 01 down, 10 left, 11 right)
//   state_e : scheduler state encoding (STOPPED / RUNNING)
//   opposite(): returns the reverse of a direction (same axis bit, flipped sense bit)
package snake_pkg;

  localparam int unsigned DIR_W   = 2;
  localparam int unsigned COUNT_W = 3;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_e;

  function automatic logic [1:0] opposite(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Circular queue of pending direction commands.
// Ports: clk, reset (sync, active-high), flush (drop all entries),
//        push/din (enqueue), pop (dequeue), head (oldest entry),
//        tail (newest entry), count (occupancy, 0..DEPTH).
// A push on a full queue is accepted only when a pop happens in the same cycle.
module dir_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] din,
  output logic [1:0] head,
  output logic [1:0] tail,
  output logic [2:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [1:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] tail_idx;
  logic             do_pop;
  logic             do_push;

  assign do_pop   = pop && (count != 3'd0);
  assign do_push  = push && ((count < 3'(DEPTH)) || do_pop);
  assign tail_idx = (wr_ptr == '0) ? LAST : wr_ptr - 1'b1;
  assign head     = mem[rd_ptr];
  assign tail     = mem[tail_idx];

  // Entry storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap at DEPTH, which need not be a power of two
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 3'd0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + 3'(do_push) - 3'(do_pop);
    end
  end

endmodule

// File: rtl/direction_scheduler.sv
// Direction scheduler for a snake game: filters debounced key pulses,
// queues accepted turns and commits one per game tick.
// Ports: VGA_CLK (clock), reset (sync, active-high), X0..X3_deb (up/down/left/right
//        key pulses), tick (game step), halt (game over), dir (committed direction),
//        step (move pulse), running, pending (queued count), drop (queue overflow).
// Macro DIR_QUEUE_EN: defined -> QUEUE_DEPTH-entry dir_fifo; undefined -> one-entry
//        latest-wins register, drop tied low.
module direction_scheduler
  import snake_pkg::*;
#(
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter logic [1:0]  INIT_DIR    = 2'b11
) (
  input  logic       VGA_CLK,
  input  logic       reset,
  input  logic       X0_deb,
  input  logic       X1_deb,
  input  logic       X2_deb,
  input  logic       X3_deb,
  input  logic       tick,
  input  logic       halt,
  output logic [1:0] dir,
  output logic       step,
  output logic       running,
  output logic [2:0] pending,
  output logic       drop
);

  if (QUEUE_DEPTH < 1 || QUEUE_DEPTH > 4) begin : g_depth_check
    $error("direction_scheduler: QUEUE_DEPTH must be in 1..4");
  end

  state_e     state_q;
  state_e     state_d;
  logic       key_valid_c;
  logic [1:0] cand_c;
  logic [1:0] ref_c;
  logic [1:0] head_c;
  logic [1:0] tail_c;
  logic [2:0] count_c;
  logic       full_c;
  logic       pass_c;
  logic       push_c;
  logic       pop_c;
  logic       flush_c;
  logic       step_d;
  logic       drop_d;
  logic [1:0] dir_d;

  // Fixed key priority: up > down > left > right
  always_comb begin
    key_valid_c = 1'b1;
    cand_c      = DIR_UP;
    if (X0_deb)      cand_c = DIR_UP;
    else if (X1_deb) cand_c = DIR_DOWN;
    else if (X2_deb) cand_c = DIR_LEFT;
    else if (X3_deb) cand_c = DIR_RIGHT;
    else             key_valid_c = 1'b0;
  end

`ifdef DIR_QUEUE_EN
  dir_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk   (VGA_CLK),
    .reset (reset),
    .flush (flush_c),
    .push  (push_c),
    .pop   (pop_c),
    .din   (cand_c),
    .head  (head_c),
    .tail  (tail_c),
    .count (count_c)
  );

  assign full_c = (count_c >= 3'(QUEUE_DEPTH));
`else
  logic [1:0] slot_q;
  logic       slot_valid_q;

  // Single slot: a newer accepted key simply replaces the older one
  always_ff @(posedge VGA_CLK) begin
    if (reset || flush_c) begin
      slot_q       <= 2'b00;
      slot_valid_q <= 1'b0;
    end else if (push_c) begin
      slot_q       <= cand_c;
      slot_valid_q <= 1'b1;
    end else if (pop_c) begin
      slot_valid_q <= 1'b0;
    end
  end

  assign head_c  = slot_q;
  assign tail_c  = slot_q;
  assign count_c = {2'b00, slot_valid_q};
  assign full_c  = 1'b0;
`endif

  assign pending = count_c;

  // State register
  always_ff @(posedge VGA_CLK) begin
    if (reset) state_q <= STOPPED;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      STOPPED: if (push_c) state_d = RUNNING;
      RUNNING: if (halt)   state_d = STOPPED;
      default: state_d = STOPPED;
    endcase
  end

  // Queue control and next output values.
  // The tail survives a same-cycle pop unless the queue empties, and then the
  // popped head (== tail) is what gets committed, so tail is the reference either way.
  always_comb begin
    push_c  = 1'b0;
    pop_c   = 1'b0;
    flush_c = 1'b0;
    pass_c  = 1'b0;
    step_d  = 1'b0;
    drop_d  = 1'b0;
    dir_d   = dir;
    ref_c   = (count_c != 3'd0) ? tail_c : dir;
    case (state_q)
      STOPPED: begin
        // Restarting in the current direction is allowed; only a reversal is refused
        pass_c = key_valid_c && (cand_c != opposite(dir));
        push_c = pass_c;
      end
      RUNNING: begin
        if (halt) begin
          flush_c = 1'b1;
        end else begin
          step_d = tick;
          pop_c  = tick && (count_c != 3'd0);
          if (pop_c) dir_d = head_c;
          pass_c = key_valid_c && (cand_c != ref_c) && (cand_c != opposite(ref_c));
          push_c = pass_c && (!full_c || pop_c);
          drop_d = pass_c && full_c && !pop_c;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      dir     <= INIT_DIR;
      step    <= 1'b0;
      running <= 1'b0;
      drop    <= 1'b0;
    end else begin
      dir     <= dir_d;
      step    <= step_d;
      running <= (state_d == RUNNING);
      drop    <= drop_d;
    end
  end

endmodule

// File: tb/tb_direction_scheduler.sv
// Self-checking bench for direction_scheduler: directed scenarios followed by
// random key/tick/halt/reset traffic, checked every cycle against a queue-based model.
// Honours DIR_QUEUE_EN the same way the design does.
module tb_direction_scheduler;

  localparam int unsigned DEPTH = 2;
  localparam logic [1:0]  INIT  = 2'b11;
`ifdef DIR_QUEUE_EN
  localparam bit QMODE = 1'b1;
`else
  localparam bit QMODE = 1'b0;
`endif

  logic       VGA_CLK = 1'b0;
  logic       reset   = 1'b1;
  logic       X0_deb  = 1'b0;
  logic       X1_deb  = 1'b0;
  logic       X2_deb  = 1'b0;
  logic       X3_deb  = 1'b0;
  logic       tick    = 1'b0;
  logic       halt    = 1'b0;
  logic [1:0] dir;
  logic       step;
  logic       running;
  logic [2:0] pending;
  logic       drop;

  int chk_pass  = 0;
  int chk_total = 0;
  int cyc_no    = 0;

  // Reference model state
  bit         m_run;
  logic [1:0] m_dir;
  logic [1:0] m_q[$];
  bit         m_step;
  bit         m_drop;

  direction_scheduler #(
    .QUEUE_DEPTH (DEPTH),
    .INIT_DIR    (INIT)
  ) dut (
    .VGA_CLK (VGA_CLK),
    .reset   (reset),
    .X0_deb  (X0_deb),
    .X1_deb  (X1_deb),
    .X2_deb  (X2_deb),
    .X3_deb  (X3_deb),
    .tick    (tick),
    .halt    (halt),
    .dir     (dir),
    .step    (step),
    .running (running),
    .pending (pending),
    .drop    (drop)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_total++;
    if (got === exp) chk_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc_no, got, exp);
  endtask

  // Game rules applied to one clock edge; k[0]=up .. k[3]=right
  task automatic model_step(input logic [3:0] k, input logic t, input logic h, input logic r);
    logic [1:0] cand;
    logic [1:0] refd;
    logic [1:0] com;
    bit         kv;
    bit         have_com;
    m_step = 1'b0;
    m_drop = 1'b0;
    if (r) begin
      m_run = 1'b0;
      m_dir = INIT;
      m_q.delete();
      return;
    end
    kv   = 1'b0;
    cand = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      if (k[i]) begin
        kv   = 1'b1;
        cand = 2'(i);
      end
    end
    if (!m_run) begin
      if (kv && cand != (m_dir ^ 2'b01)) begin
        m_q.push_back(cand);
        m_run = 1'b1;
      end
      return;
    end
    if (h) begin
      m_run = 1'b0;
      m_q.delete();
      return;
    end
    have_com = 1'b0;
    com      = 2'b00;
    if (t) begin
      m_step = 1'b1;
      if (m_q.size() > 0) begin
        com      = m_q.pop_front();
        have_com = 1'b1;
        m_dir    = com;
      end
    end
    if (m_q.size() > 0) refd = m_q[$];
    else if (have_com)  refd = com;
    else                refd = m_dir;
    if (kv && cand != refd && cand != (refd ^ 2'b01)) begin
      if (!QMODE) begin
        m_q.delete();
        m_q.push_back(cand);
      end else if (m_q.size() < int'(DEPTH)) begin
        m_q.push_back(cand);
      end else begin
        m_drop = 1'b1;
      end
    end
  endtask

  // Drive one cycle, advance the model at the edge, compare just after it
  task automatic cyc(input logic [3:0] k, input logic t, input logic h, input logic r);
    {X3_deb, X2_deb, X1_deb, X0_deb} = k;
    tick  = t;
    halt  = h;
    reset = r;
    @(posedge VGA_CLK);
    model_step(k, t, h, r);
    cyc_no++;
    #1;
    check("dir",     32'(dir),     32'(m_dir));
    check("step",    32'(step),    32'(m_step));
    check("running", 32'(running), 32'(m_run));
    check("pending", 32'(pending), 32'(m_q.size()));
    check("drop",    32'(drop),    32'(m_drop));
    {X3_deb, X2_deb, X1_deb, X0_deb} = 4'b0000;
    tick  = 1'b0;
    halt  = 1'b0;
    reset = 1'b0;
  endtask

  localparam logic [3:0] K_UP = 4'b0001, K_DN = 4'b0010, K_LT = 4'b0100, K_RT = 4'b1000;

  initial begin
    logic [3:0] k;
    m_run = 1'b0;
    m_dir = INIT;

    cyc(4'b0, 1'b0, 1'b0, 1'b1);
    cyc(4'b0, 1'b0, 1'b0, 1'b1);
    check("rst_dir", 32'(dir), 32'h3);
    check("rst_running", 32'(running), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);

    // Start with right, then commit it
    cyc(K_RT, 1'b0, 1'b0, 1'b0);
    check("start_running", 32'(running), 32'h1);
    check("start_pending", 32'(pending), 32'h1);
    cyc(4'b0, 1'b1, 1'b0, 1'b0);
    check("start_step", 32'(step), 32'h1);
    check("start_dir", 32'(dir), 32'h3);
    check("start_pending0", 32'(pending), 32'h0);

    // Reversal refused, perpendicular accepted
    cyc(K_LT, 1'b0, 1'b0, 1'b0);
    check("reverse_pending", 32'(pending), 32'h0);
    cyc(K_UP, 1'b0, 1'b0, 1'b0);
    check("turn_pending", 32'(pending), 32'h1);
    cyc(4'b0, 1'b1, 1'b0, 1'b0);
    check("turn_dir", 32'(dir), 32'h0);

    // Two keys in one cycle: up wins over left
    cyc(K_RT, 1'b0, 1'b0, 1'b0);
    cyc(4'b0, 1'b1, 1'b0, 1'b0);
    cyc(K_UP | K_LT, 1'b0, 1'b0, 1'b0);
    check("prio_pending", 32'(pending), 32'h1);
    check("prio_drop", 32'(drop), 32'h0);
    cyc(4'b0, 1'b1, 1'b0, 1'b0);
    check("prio_dir", 32'(dir), 32'h0);

    if (QMODE) begin
      // Overflow on a depth-2 queue
      cyc(K_RT, 1'b0, 1'b0, 1'b0);
      cyc(4'b0, 1'b1, 1'b0, 1'b0);
      cyc(K_UP, 1'b0, 1'b0, 1'b0);
      cyc(K_LT, 1'b0, 1'b0, 1'b0);
      cyc(K_UP, 1'b0, 1'b0, 1'b0);
      check("ovf_drop", 32'(drop), 32'h1);
      check("ovf_pending", 32'(pending), 32'h2);
      cyc(4'b0, 1'b0, 1'b0, 1'b0);
      check("ovf_drop_once", 32'(drop), 32'h0);
      cyc(4'b0, 1'b1, 1'b0, 1'b0);
      check("ovf_dir1", 32'(dir), 32'h0);
      cyc(4'b0, 1'b1, 1'b0, 1'b0);
      check("ovf_dir2", 32'(dir), 32'h2);
      // Full queue with simultaneous pop and push
      cyc(K_UP, 1'b0, 1'b0, 1'b0);
      cyc(K_RT, 1'b0, 1'b0, 1'b0);
      cyc(K_DN, 1'b1, 1'b0, 1'b0);
      check("fullpp_dir", 32'(dir), 32'h0);
      check("fullpp_pending", 32'(pending), 32'h2);
      check("fullpp_drop", 32'(drop), 32'h0);
    end else begin
      // Latest accepted key replaces the older one
      cyc(K_LT, 1'b0, 1'b0, 1'b0);
      cyc(K_DN, 1'b0, 1'b0, 1'b0);
      check("latest_pending", 32'(pending), 32'h1);
      cyc(4'b0, 1'b1, 1'b0, 1'b0);
      check("latest_dir", 32'(dir), 32'h1);
      cyc(K_LT, 1'b0, 1'b0, 1'b0);
    end

    // Halt beats a same-cycle tick
    cyc(4'b0, 1'b1, 1'b1, 1'b0);
    check("halt_step", 32'(step), 32'h0);
    check("halt_running", 32'(running), 32'h0);
    check("halt_pending", 32'(pending), 32'h0);
    check("halt_dir", 32'(dir), QMODE ? 32'h0 : 32'h1);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < 4; b++) k[b] = ($urandom_range(0, 4) == 0);
      cyc(k, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
          $urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
